// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding,
// opcodes, ALU/mux select constants and the control-word layout.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ITYPEWB = 4'd10,
    S_JEX     = 4'd11,
    S_SLTIEX  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_SLTI  = 2'b11;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       branch;
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Target state leaving DECODE; FETCH doubles as the "unrecognised" answer.
  function automatic state_t dispatch_state(input logic [5:0] op);
    state_t s;
    unique case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = S_RTYPEEX;
      OP_BEQ:       s = S_BEQEX;
      OP_ADDI:      s = S_ADDIEX;
      OP_SLTI:      s = S_SLTIEX;
      OP_J:         s = S_JEX;
      default:      s = S_FETCH;
    endcase
    return s;
  endfunction

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational Moore output decoder: maps the current state code to the
// datapath control word. Unused codes fall through to the all-zero word.
module mc_outdec
  import mips_pkg::*;
(
  input  logic [3:0]        state_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (state_i)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = ALUSRCB_FOUR;
      end
      S_DECODE: begin
        ctrl.alusrcb = ALUSRCB_IMMSH;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
      end
      S_SLTIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_SLTI;
      end
      S_ITYPEWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
    ctrl_o = ctrl;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// state-to-output decoder; write enables are held off while reset is high.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       branch,
  output logic       iord,
  output logic       alusrca,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  state_t            state_q;
  state_t            state_d;
  logic              illegal_d;
  logic [CTRL_W-1:0] ctrl_bits;
  ctrl_t             ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        state_d   = dispatch_state(op);
        illegal_d = ~op_is_legal(op);
      end
      // op is re-examined here to split loads from stores.
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ITYPEWB;
      S_SLTIEX:  state_d = S_ITYPEWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl_bits)
  );

  assign ctrl = ctrl_t'(ctrl_bits);

  assign pcwrite  = ctrl.pcwrite  & ~reset;
  assign memwrite = ctrl.memwrite & ~reset;
  assign irwrite  = ctrl.irwrite  & ~reset;
  assign regwrite = ctrl.regwrite & ~reset;
  assign branch   = ctrl.branch   & ~reset;
  assign illegal  = illegal_d     & ~reset;
  assign iord     = ctrl.iord;
  assign alusrca  = ctrl.alusrca;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected per-cycle
// observations, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       pcwrite, memwrite, irwrite, regwrite, branch;
  logic       iord, alusrca, regdst, memtoreg, illegal;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  logic [19:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .pcwrite  (pcwrite),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .branch   (branch),
    .iord     (iord),
    .alusrca  (alusrca),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .illegal  (illegal),
    .state    (state)
  );

  // {pcw,memw,irw,regw,br,iord,alusrca,regdst,memtoreg, alusrcb, pcsrc, aluop}
  function automatic logic [14:0] exp_ctrl(input logic [3:0] s);
    logic [14:0] c;
    case (s)
      4'd0:    c = 15'b101000000_01_00_00;
      4'd1:    c = 15'b000000000_11_00_00;
      4'd2:    c = 15'b000000100_10_00_00;
      4'd3:    c = 15'b000001000_00_00_00;
      4'd4:    c = 15'b000100001_00_00_00;
      4'd5:    c = 15'b010001000_00_00_00;
      4'd6:    c = 15'b000000100_00_00_10;
      4'd7:    c = 15'b000100010_00_00_00;
      4'd8:    c = 15'b000010100_00_01_01;
      4'd9:    c = 15'b000000100_10_00_00;
      4'd10:   c = 15'b000100000_00_00_00;
      4'd11:   c = 15'b100000000_00_10_00;
      4'd12:   c = 15'b000000100_10_00_11;
      default: c = 15'b0;
    endcase
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push_seq(input string nm, input logic [19:0] seq, input int n, input bit ill);
    for (int i = 0; i < n; i++) begin
      logic [3:0] s;
      s = seq[19-4*i -: 4];
      exp_q.push_back({s, exp_ctrl(s), (ill && (s == 4'd1))});
      name_q.push_back($sformatf("%s_c%0d", nm, i));
    end
  endtask

  // Called just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input string nm, input logic [5:0] opc, input logic [19:0] seq,
                           input int n, input bit ill, input bit hold);
    op = opc;
    push_seq(nm, seq, n, ill);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 && !hold) op = 6'h3f;
    end
    $display("[TB] %s op=%b issued, %0d cycles", nm, opc, n);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      logic [19:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {state, pcwrite, memwrite, irwrite, regwrite, branch, iord, alusrca, regdst,
            memtoreg, alusrcb, pcsrc, aluop, illegal};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got %05h, expected %05h", nm, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_wen", {26'd0, pcwrite, irwrite, memwrite, regwrite, branch, illegal}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_state", {28'd0, state}, 32'd0);
    reset = 1'b0;

    run_instr("lw",    6'b100011, 20'h01234, 5, 1'b0, 1'b1);
    run_instr("sw",    6'b101011, 20'h01250, 4, 1'b0, 1'b1);
    run_instr("rtype", 6'b000000, 20'h01670, 4, 1'b0, 1'b0);
    run_instr("addi",  6'b001000, 20'h019A0, 4, 1'b0, 1'b0);
    run_instr("slti",  6'b001010, 20'h01CA0, 4, 1'b0, 1'b0);
    run_instr("j",     6'b000010, 20'h01B00, 3, 1'b0, 1'b0);
    run_instr("beq",   6'b000100, 20'h01800, 3, 1'b0, 1'b0);
    run_instr("ill3f", 6'b111111, 20'h01000, 2, 1'b1, 1'b0);
    run_instr("ill20", 6'b100000, 20'h01000, 2, 1'b1, 1'b0);

    // lw interrupted by an asynchronous reset while in MEMRD
    op = 6'b100011;
    push_seq("lw_rst", 20'h01230, 4, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_state", {28'd0, state}, 32'd0);
    chk("midrst_wen", {26'd0, pcwrite, irwrite, memwrite, regwrite, branch, illegal}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_state", {28'd0, state}, 32'd0);
    chk("midrst_hold_wen", {26'd0, pcwrite, irwrite, memwrite, regwrite, branch, illegal}, 32'd0);
    reset = 1'b0;
    $display("[TB] reset pulse during MEMRD applied");

    run_instr("rtype2", 6'b000000, 20'h01670, 4, 1'b0, 1'b0);
    run_instr("beq2",   6'b000100, 20'h01800, 3, 1'b0, 1'b0);
    run_instr("ill2",   6'b111111, 20'h01000, 2, 1'b1, 1'b0);
    run_instr("lw2",    6'b100011, 20'h01234, 5, 1'b0, 1'b1);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
